// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg
//   Shared encodings for the micro-sequencer: sequencing operations, branch
//   condition selectors, sequencer state, and the microword field layout.
//   Microword layout, MSB first: {ctrl, seq_op[2:0], cond_sel[2:0], next_addr}.
package micro_seq_pkg;

  localparam int unsigned SEQ_OP_W   = 3;
  localparam int unsigned COND_SEL_W = 3;

  typedef enum logic [SEQ_OP_W-1:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_DISPATCH = 3'd2,
    SEQ_CBR      = 3'd3,
    SEQ_CALL     = 3'd4,
    SEQ_RET      = 3'd5,
    SEQ_FETCH    = 3'd6,
    SEQ_HALT     = 3'd7
  } seq_op_e;

  typedef enum logic [COND_SEL_W-1:0] {
    COND_ZF     = 3'd0,
    COND_CF     = 3'd1,
    COND_OF     = 3'd2,
    COND_SF     = 3'd3,
    COND_GEZ    = 3'd4,
    COND_LT     = 3'd5,
    COND_ALWAYS = 3'd6,
    COND_NEVER  = 3'd7
  } cond_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

  // Total microword width for a given control width and microaddress width.
  function automatic int unsigned uword_width(input int unsigned cw_w,
                                              input int unsigned ua_w);
    return cw_w + SEQ_OP_W + COND_SEL_W + ua_w;
  endfunction

  // next_addr occupies bits [ua_w-1:0]; the other fields sit above it.
  function automatic int unsigned cond_sel_lsb(input int unsigned ua_w);
    return ua_w;
  endfunction

  function automatic int unsigned seq_op_lsb(input int unsigned ua_w);
    return ua_w + COND_SEL_W;
  endfunction

  function automatic int unsigned ctrl_lsb(input int unsigned ua_w);
    return ua_w + COND_SEL_W + SEQ_OP_W;
  endfunction

  // flags = {ZF, CF, OF, SF}
  function automatic logic cond_eval(input cond_sel_e sel, input logic [3:0] flags);
    logic zf, cf, of, sf;
    logic res;
    zf = flags[3];
    cf = flags[2];
    of = flags[1];
    sf = flags[0];
    case (sel)
      COND_ZF:     res = zf;
      COND_CF:     res = cf;
      COND_OF:     res = of;
      COND_SF:     res = sf;
      COND_GEZ:    res = !sf || zf;
      COND_LT:     res = sf && !zf;
      COND_ALWAYS: res = 1'b1;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/micro_seq_ram.sv
// micro_seq_ram
//   Control store: one write port, one synchronous read port. The read
//   register doubles as the microinstruction register (UIR); it is the only
//   resettable element here, the array contents are not reset.
//   A read of an address written in the same cycle returns the old data.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   we, waddr, wdata    write port
//   re, raddr           read enable / address; rdata updates only when re=1
//   rdata               registered read data
module micro_seq_ram #(
  parameter int unsigned WIDTH = 45,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Microprogrammed control sequencer. Holds the control address register
//   (CAR) and the microinstruction register (UIR, inside the control store's
//   read register), selects the next microaddress each cycle, and drives the
//   control field of the current microword to the datapath.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ir_opcode                          opcode used by DISPATCH
//   alu_flags                          {ZF,CF,OF,SF} used by CBR
//   stall                              freezes sequencing while in RUN
//   run                                pulse to leave HALT
//   ucode_we/ucode_addr/ucode_wdata    control-store write port
//   disp_we/disp_opcode/disp_addr      dispatch-table write port
//   ctrl                               control field of current microword
//   uaddr                              current CAR
//   halted                             sequencer is in HALT
//   stack_err                          sticky return-stack over/underflow
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int unsigned CW_W         = 32,
  parameter int unsigned UADDR_W      = 7,
  parameter int unsigned OPC_W        = 8,
  parameter int unsigned STACK_DEPTH  = 2,
  parameter int unsigned FETCH_ADDR   = 0,
  parameter int unsigned DEFAULT_ADDR = 2**UADDR_W - 1,
  localparam int unsigned UW          = uword_width(CW_W, UADDR_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   ir_opcode,
  input  logic [3:0]         alu_flags,
  input  logic               stall,
  input  logic               run,
  input  logic               ucode_we,
  input  logic [UADDR_W-1:0] ucode_addr,
  input  logic [UW-1:0]      ucode_wdata,
  input  logic               disp_we,
  input  logic [OPC_W-1:0]   disp_opcode,
  input  logic [UADDR_W-1:0] disp_addr,
  output logic [CW_W-1:0]    ctrl,
  output logic [UADDR_W-1:0] uaddr,
  output logic               halted,
  output logic               stack_err
);

  localparam int unsigned CTRL_LSB = ctrl_lsb(UADDR_W);
  localparam int unsigned SEQ_LSB  = seq_op_lsb(UADDR_W);
  localparam int unsigned COND_LSB = cond_sel_lsb(UADDR_W);
  localparam int unsigned SP_W     = $clog2(STACK_DEPTH + 1);

  localparam logic [UADDR_W-1:0] FETCH_UA   = UADDR_W'(FETCH_ADDR);
  localparam logic [UADDR_W-1:0] DEFAULT_UA = UADDR_W'(DEFAULT_ADDR);
  localparam logic [SP_W-1:0]    SP_FULL    = SP_W'(STACK_DEPTH);

  seq_state_e state, state_next;

  logic [UADDR_W-1:0] car, car_next, car_inc;
  logic [UW-1:0]      uir;
  logic               load_uir;

  seq_op_e            op;
  cond_sel_e          cs;
  logic [UADDR_W-1:0] na;

  // Return stack; sized to a power of two so sp indexes it without width
  // adaptation. Entries at or above STACK_DEPTH are never written.
  logic [UADDR_W-1:0] stack [2**SP_W];
  logic [SP_W-1:0]    sp;
  logic               push, pop, flush, set_err;
  logic               stack_full, stack_empty;

  logic [UADDR_W-1:0] disp_tbl [2**OPC_W];
  logic [2**OPC_W-1:0] disp_valid;
  logic [UADDR_W-1:0] disp_target;

  micro_seq_ram #(
    .WIDTH (UW),
    .DEPTH (2**UADDR_W),
    .AW    (UADDR_W)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ucode_we),
    .waddr (ucode_addr),
    .wdata (ucode_wdata),
    .re    (load_uir),
    .raddr (car_next),
    .rdata (uir)
  );

  assign op          = seq_op_e'(uir[SEQ_LSB +: SEQ_OP_W]);
  assign cs          = cond_sel_e'(uir[COND_LSB +: COND_SEL_W]);
  assign na          = uir[UADDR_W-1:0];
  assign car_inc     = car + UADDR_W'(1);
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign disp_target = disp_valid[ir_opcode] ? disp_tbl[ir_opcode] : DEFAULT_UA;
  assign uaddr       = car;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      car   <= FETCH_UA;
    end else begin
      state <= state_next;
      car   <= car_next;
    end
  end

  always_comb begin
    state_next = state;
    car_next   = car;
    load_uir   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    set_err    = 1'b0;
    ctrl       = '0;
    halted     = 1'b0;
    case (state)
      ST_BOOT: begin
        car_next   = FETCH_UA;
        load_uir   = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        ctrl = uir[CTRL_LSB +: CW_W];
        if (!stall) begin
          case (op)
            SEQ_NEXT: begin
              car_next = car_inc;
              load_uir = 1'b1;
            end
            SEQ_JUMP: begin
              car_next = na;
              load_uir = 1'b1;
            end
            SEQ_DISPATCH: begin
              car_next = disp_target;
              load_uir = 1'b1;
            end
            SEQ_CBR: begin
              car_next = cond_eval(cs, alu_flags) ? na : car_inc;
              load_uir = 1'b1;
            end
            SEQ_CALL: begin
              if (stack_full) begin
                set_err    = 1'b1;
                state_next = ST_HALT;
              end else begin
                push     = 1'b1;
                car_next = na;
                load_uir = 1'b1;
              end
            end
            SEQ_RET: begin
              if (stack_empty) begin
                set_err    = 1'b1;
                state_next = ST_HALT;
              end else begin
                pop      = 1'b1;
                car_next = stack[sp - SP_W'(1)];
                load_uir = 1'b1;
              end
            end
            SEQ_FETCH: begin
              car_next = FETCH_UA;
              load_uir = 1'b1;
            end
            default: begin
              state_next = ST_HALT;
            end
          endcase
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        // Restart: CAR moves to the fetch routine now; the following BOOT
        // cycle reloads the UIR from it.
        if (run) begin
          car_next   = FETCH_UA;
          flush      = 1'b1;
          state_next = ST_BOOT;
        end
      end
      default: begin
        state_next = ST_BOOT;
        car_next   = FETCH_UA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      if (flush) begin
        sp <= '0;
      end else if (push) begin
        sp <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end
      if (set_err) begin
        stack_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stack[sp] <= car_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid <= '0;
    end else if (disp_we) begin
      disp_valid[disp_opcode] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (disp_we) begin
      disp_tbl[disp_opcode] <= disp_addr;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer
//   Directed bench for micro_sequencer: loads a small microprogram, then walks
//   dispatch, conditional branch, call/return, halt/run, stall, overflow,
//   wrap and mid-routine reset scenarios. Expected outputs are queued as each
//   step is driven and compared once the DUT has advanced.
module tb_micro_sequencer;

  localparam int unsigned CW_W    = 32;
  localparam int unsigned UADDR_W = 7;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned UW      = CW_W + 6 + UADDR_W;

  localparam logic [2:0] OP_NEXT = 3'd0, OP_DISP = 3'd2, OP_CBR = 3'd3,
                         OP_CALL = 3'd4, OP_RET = 3'd5, OP_FETCH = 3'd6,
                         OP_HALT = 3'd7;
  localparam logic [2:0] C_GEZ = 3'd4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [OPC_W-1:0]   ir_opcode;
  logic [3:0]         alu_flags;
  logic               stall, run;
  logic               ucode_we;
  logic [UADDR_W-1:0] ucode_addr;
  logic [UW-1:0]      ucode_wdata;
  logic               disp_we;
  logic [OPC_W-1:0]   disp_opcode;
  logic [UADDR_W-1:0] disp_addr;
  logic [CW_W-1:0]    ctrl;
  logic [UADDR_W-1:0] uaddr;
  logic               halted, stack_err;

  always #5 clk = ~clk;

  micro_sequencer #(
    .CW_W         (CW_W),
    .UADDR_W      (UADDR_W),
    .OPC_W        (OPC_W),
    .STACK_DEPTH  (2),
    .FETCH_ADDR   (0),
    .DEFAULT_ADDR (127)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir_opcode   (ir_opcode),
    .alu_flags   (alu_flags),
    .stall       (stall),
    .run         (run),
    .ucode_we    (ucode_we),
    .ucode_addr  (ucode_addr),
    .ucode_wdata (ucode_wdata),
    .disp_we     (disp_we),
    .disp_opcode (disp_opcode),
    .disp_addr   (disp_addr),
    .ctrl        (ctrl),
    .uaddr       (uaddr),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  typedef struct {
    string              tag;
    logic [UADDR_W-1:0] ua;
    logic [CW_W-1:0]    c;
    logic               h;
    logic               e;
  } exp_t;

  exp_t sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  function automatic logic [UW-1:0] mw(input logic [CW_W-1:0] c, input logic [2:0] op,
                                       input logic [2:0] cs, input logic [UADDR_W-1:0] na);
    return {c, op, cs, na};
  endfunction

  task automatic check_one(input string tag, input string what,
                           input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s %s: got %0h expected %0h", tag, what, got, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    check_one(e.tag, "uaddr",     32'(uaddr),     32'(e.ua));
    check_one(e.tag, "ctrl",      ctrl,           e.c);
    check_one(e.tag, "halted",    32'(halted),    32'(e.h));
    check_one(e.tag, "stack_err", 32'(stack_err), 32'(e.e));
  endtask

  // Queue the expectation for the state after the next rising edge, then
  // compare on the following falling edge.
  task automatic step(input string tag, input logic [UADDR_W-1:0] ua,
                      input logic [CW_W-1:0] c, input logic h, input logic e);
    sb.push_back('{tag, ua, c, h, e});
    @(negedge clk);
    pop_check();
  endtask

  // Compare without a clock edge (asynchronous effects).
  task automatic now_check(input string tag, input logic [UADDR_W-1:0] ua,
                           input logic [CW_W-1:0] c, input logic h, input logic e);
    sb.push_back('{tag, ua, c, h, e});
    #1;
    pop_check();
  endtask

  task automatic wr_uc(input logic [UADDR_W-1:0] a, input logic [UW-1:0] w);
    ucode_we    = 1'b1;
    ucode_addr  = a;
    ucode_wdata = w;
    @(negedge clk);
    ucode_we    = 1'b0;
  endtask

  task automatic wr_disp(input logic [OPC_W-1:0] opc, input logic [UADDR_W-1:0] a);
    disp_we     = 1'b1;
    disp_opcode = opc;
    disp_addr   = a;
    @(negedge clk);
    disp_we     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ir_opcode = '0; alu_flags = '0; stall = 1'b0; run = 1'b0;
    ucode_we = 1'b0; ucode_addr = '0; ucode_wdata = '0;
    disp_we = 1'b0; disp_opcode = '0; disp_addr = '0;
    @(negedge clk);

    // Program load under reset; address 0 parks the sequencer in HALT first.
    wr_uc(7'd0,   mw(32'h0,   OP_HALT,  3'd0,  7'd0));
    wr_uc(7'd1,   mw(32'h11,  OP_DISP,  3'd0,  7'd0));
    wr_uc(7'd14,  mw(32'h201, OP_FETCH, 3'd0,  7'd0));
    wr_uc(7'd25,  mw(32'h25,  OP_CBR,   C_GEZ, 7'd27));
    wr_uc(7'd26,  mw(32'h26,  OP_FETCH, 3'd0,  7'd0));
    wr_uc(7'd27,  mw(32'h27,  OP_FETCH, 3'd0,  7'd0));
    wr_uc(7'd40,  mw(32'h40,  OP_CALL,  3'd0,  7'd50));
    wr_uc(7'd50,  mw(32'h50,  OP_CALL,  3'd0,  7'd60));
    wr_uc(7'd60,  mw(32'h60,  OP_CALL,  3'd0,  7'd70));
    wr_uc(7'd70,  mw(32'h70,  OP_FETCH, 3'd0,  7'd0));
    wr_uc(7'd80,  mw(32'h80,  OP_CALL,  3'd0,  7'd90));
    wr_uc(7'd90,  mw(32'h90,  OP_RET,   3'd0,  7'd0));
    wr_uc(7'd81,  mw(32'h81,  OP_FETCH, 3'd0,  7'd0));
    wr_uc(7'd100, mw(32'h100, OP_HALT,  3'd0,  7'd0));
    wr_uc(7'd127, mw(32'h7F,  OP_NEXT,  3'd0,  7'd0));

    now_check("reset", 7'd0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    now_check("boot", 7'd0, 32'h0, 1'b0, 1'b0);
    step("halt_word", 7'd0, 32'h0, 1'b0, 1'b0);
    step("halted", 7'd0, 32'h0, 1'b1, 1'b0);

    wr_disp(8'h03, 7'd14);
    wr_disp(8'h10, 7'd25);
    wr_disp(8'h20, 7'd40);
    wr_disp(8'h30, 7'd80);
    wr_disp(8'h50, 7'd100);
    wr_uc(7'd0, mw(32'h9, OP_NEXT, 3'd0, 7'd0));

    // Fetch/dispatch loop with opcode 0x03
    ir_opcode = 8'h03;
    run = 1'b1;
    step("run_boot", 7'd0, 32'h0, 1'b0, 1'b0);
    run = 1'b0;
    step("fetch0", 7'd0, 32'h9, 1'b0, 1'b0);
    step("disp1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("disp14", 7'd14, 32'h201, 1'b0, 1'b0);
    step("back0", 7'd0, 32'h9, 1'b0, 1'b0);

    // Stall three cycles
    stall = 1'b1;
    step("stall_a", 7'd0, 32'h9, 1'b0, 1'b0);
    step("stall_b", 7'd0, 32'h9, 1'b0, 1'b0);
    step("stall_c", 7'd0, 32'h9, 1'b0, 1'b0);
    stall = 1'b0;
    step("resume1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("resume14", 7'd14, 32'h201, 1'b0, 1'b0);
    step("resume0", 7'd0, 32'h9, 1'b0, 1'b0);

    // CBR GEZ: SF=0 -> taken
    ir_opcode = 8'h10;
    step("cbr_a1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("cbr_a25", 7'd25, 32'h25, 1'b0, 1'b0);
    alu_flags = 4'b0000;
    step("cbr_sf0", 7'd27, 32'h27, 1'b0, 1'b0);
    step("cbr_b0", 7'd0, 32'h9, 1'b0, 1'b0);
    step("cbr_b1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("cbr_b25", 7'd25, 32'h25, 1'b0, 1'b0);
    alu_flags = 4'b0001;  // SF=1, ZF=0 -> not taken
    step("cbr_sf1", 7'd26, 32'h26, 1'b0, 1'b0);
    step("cbr_c0", 7'd0, 32'h9, 1'b0, 1'b0);
    step("cbr_c1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("cbr_c25", 7'd25, 32'h25, 1'b0, 1'b0);
    alu_flags = 4'b1001;  // SF=1, ZF=1 -> taken
    step("cbr_sf1zf1", 7'd27, 32'h27, 1'b0, 1'b0);
    alu_flags = 4'b0000;
    step("cbr_end", 7'd0, 32'h9, 1'b0, 1'b0);

    // CALL / RET
    ir_opcode = 8'h30;
    step("cr1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("call80", 7'd80, 32'h80, 1'b0, 1'b0);
    step("sub90", 7'd90, 32'h90, 1'b0, 1'b0);
    step("ret81", 7'd81, 32'h81, 1'b0, 1'b0);
    step("cr_end", 7'd0, 32'h9, 1'b0, 1'b0);

    // HALT microword and run restart
    ir_opcode = 8'h50;
    step("h1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("hword", 7'd100, 32'h100, 1'b0, 1'b0);
    step("hstate", 7'd100, 32'h0, 1'b1, 1'b0);
    step("hheld", 7'd100, 32'h0, 1'b1, 1'b0);
    run = 1'b1;
    step("h_boot", 7'd0, 32'h0, 1'b0, 1'b0);
    run = 1'b0;
    step("h_fetch", 7'd0, 32'h9, 1'b0, 1'b0);

    // Unmapped opcode -> DEFAULT_ADDR, then NEXT wraps 127 -> 0
    ir_opcode = 8'hFF;
    step("u1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("unmapped", 7'd127, 32'h7F, 1'b0, 1'b0);
    step("wrap", 7'd0, 32'h9, 1'b0, 1'b0);

    // CALL nesting beyond two entries
    ir_opcode = 8'h20;
    step("ov1", 7'd1, 32'h11, 1'b0, 1'b0);
    step("ov40", 7'd40, 32'h40, 1'b0, 1'b0);
    step("ov50", 7'd50, 32'h50, 1'b0, 1'b0);
    step("ov60", 7'd60, 32'h60, 1'b0, 1'b0);
    step("ov_halt", 7'd60, 32'h0, 1'b1, 1'b1);
    step("ov_held", 7'd60, 32'h0, 1'b1, 1'b1);
    run = 1'b1;
    step("ov_boot", 7'd0, 32'h0, 1'b0, 1'b1);
    run = 1'b0;
    step("ov_fetch", 7'd0, 32'h9, 1'b0, 1'b1);

    // Stack must be empty again after run: call/return works
    ir_opcode = 8'h30;
    step("re1", 7'd1, 32'h11, 1'b0, 1'b1);
    step("re80", 7'd80, 32'h80, 1'b0, 1'b1);
    step("re90", 7'd90, 32'h90, 1'b0, 1'b1);
    step("re81", 7'd81, 32'h81, 1'b0, 1'b1);
    step("re0", 7'd0, 32'h9, 1'b0, 1'b1);

    // Reset mid-routine
    ir_opcode = 8'h03;
    step("mr1", 7'd1, 32'h11, 1'b0, 1'b1);
    rst_n = 1'b0;
    now_check("mr_async", 7'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    now_check("mr_boot", 7'd0, 32'h0, 1'b0, 1'b0);
    step("mr_fetch", 7'd0, 32'h9, 1'b0, 1'b0);
    step("mr_disp", 7'd1, 32'h11, 1'b0, 1'b0);
    step("mr_cleared", 7'd127, 32'h7F, 1'b0, 1'b0);
    step("mr_wrap", 7'd0, 32'h9, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter CW_W, 32, control-field width driven to the datapath.
REQ-002 Parameter UADDR_W, 7, microaddress width; control store depth = 2**UADDR_W.
REQ-003 Parameter OPC_W, 8, opcode width; dispatch table depth = 2**OPC_W.
REQ-004 Parameter STACK_DEPTH, 2, microsubroutine return-stack entries (>=1).
REQ-005 Parameter FETCH_ADDR, 0, microaddress of the fetch routine.
REQ-006 Parameter DEFAULT_ADDR, 2**UADDR_W-1, dispatch target for unmapped opcodes.
REQ-007 Derived UW = CW_W+3+3+UADDR_W; microword = {ctrl[CW_W], seq_op[3], cond_sel[3], next_addr[UADDR_W]}, MSB first.
REQ-008 clk  in  1  clock, rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 ir_opcode  in  OPC_W  opcode of current instruction.
REQ-011 alu_flags  in  4  {ZF,CF,OF,SF}.
REQ-012 stall  in  1  freeze sequencing (memory wait).
REQ-013 run  in  1  single-cycle pulse, leave HALT.
REQ-014 ucode_we / ucode_addr / ucode_wdata  in  1 / UADDR_W / UW  control-store write port.
REQ-015 disp_we / disp_opcode / disp_addr  in  1 / OPC_W / UADDR_W  dispatch-table write port.
REQ-016 ctrl  out  CW_W  control signals of current microword.
REQ-017 uaddr  out  UADDR_W  current CAR.
REQ-018 halted  out  1  sequencer in HALT.
REQ-019 stack_err  out  1  sticky return-stack overflow/underflow.

Function
REQ-020 States BOOT, RUN, HALT; reset enters BOOT; BOOT lasts one cycle, sets CAR=FETCH_ADDR, loads UIR=store[FETCH_ADDR], then RUN.
REQ-021 RUN, stall=0: each cycle CAR<=next, UIR<=store[next]; ctrl = UIR.ctrl (registered, one microword per cycle, no bubbles).
REQ-022 seq_op: 0 NEXT=CAR+1; 1 JUMP=next_addr; 2 DISPATCH=table[ir_opcode]; 3 CBR=cond?next_addr:CAR+1; 4 CALL push CAR+1, go next_addr; 5 RET pop; 6 FETCH=FETCH_ADDR; 7 HALT.
REQ-023 cond_sel: 0 ZF, 1 CF, 2 OF, 3 SF, 4 GEZ=(!SF|ZF), 5 LT=(SF&!ZF), 6 always, 7 never; sampled in the cycle the CBR microword is current.
REQ-024 CAR+1 wraps modulo 2**UADDR_W, including pushed return addresses.
REQ-025 Dispatch entry never written since reset -> DEFAULT_ADDR.
REQ-026 CALL with stack full or RET with stack empty: stack_err<=1, no push/pop, state->HALT next cycle.
REQ-027 stall=1 in RUN: CAR, UIR, stack, ctrl held unchanged; flags/opcode not sampled; ignored in BOOT/HALT.
REQ-028 HALT: ctrl=0, halted=1, CAR held; entered the cycle after a HALT microword executes (that microword's ctrl driven for its one cycle).
REQ-029 run=1 in HALT: next cycle behaves as BOOT (CAR=FETCH_ADDR, UIR reloaded), stack emptied, stack_err retained; run ignored outside HALT.
REQ-030 Store/table writes take effect next cycle; same-cycle read of written address returns old data; last write wins.

Reset
REQ-031 Asynchronous rst_n low: state=BOOT, CAR=FETCH_ADDR, UIR=0, ctrl=0, halted=0, stack_err=0, stack empty, all dispatch valid bits cleared, mid-operation included.
REQ-032 Control-store contents and dispatch addresses are not reset; reloading dispatch entries after reset is required.

Structure
REQ-033 Package micro_seq_pkg holds seq_op and cond_sel encodings, state enum, microword field offset functions.
REQ-034 Control store is sub-module micro_seq_ram (1W/1R, synchronous read, parametrised width/depth); remaining logic in micro_sequencer.

Verification
REQ-035 Load store: 0 NEXT ctrl=0x9, 1 DISPATCH; table[0x03]=14, 14 FETCH ctrl=0x201; ir_opcode=0x03 -> uaddr 0,1,14,0 with ctrl 0x9,?,0x201.
REQ-036 CBR GEZ at addr 25 next_addr=27: SF=0 -> uaddr 27; SF=1,ZF=0 -> 26; SF=1,ZF=1 -> 27.
REQ-037 Unmapped opcode 0xFF after reset -> uaddr = DEFAULT_ADDR (127).
REQ-038 CALL nest depth 3 with STACK_DEPTH=2 -> stack_err=1, halted=1, ctrl=0; run pulse -> uaddr=FETCH_ADDR, stack_err stays 1.
REQ-039 stall held 3 cycles mid-routine -> uaddr/ctrl constant for 3 cycles, sequence resumes unchanged; rst_n low mid-routine -> ctrl=0 immediately, BOOT then uaddr=0.
REQ-040 NEXT at uaddr 127 -> uaddr 0 (wrap).
